// File: rtl/modexp_engine.sv
// Iterative modular exponentiation engine, left-to-right square-and-multiply over a
// bit-serial interleaved shift-add multiplier. Optional macro: MODEXP_RANGE_CHECK_EN.
module modexp_engine #(
    parameter int W  = 16,
    parameter int EW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [EW-1:0] exponent,
    input  logic [W-1:0]  modulus,
    output logic          busy,
    output logic          done,
`ifdef MODEXP_RANGE_CHECK_EN
    output logic          err,
`endif
    output logic [W-1:0]  result
);

    localparam int AW  = W + 2;
    localparam int CW  = $clog2(W);
    localparam int EIW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RED  = 3'd2,
        SQR  = 3'd3,
        MUL  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t         state_q;
    logic [W-1:0]   base_q;
    logic [EW-1:0]  exp_q;
    logic [W-1:0]   n_q;
    logic [W-1:0]   r_q;
    logic [W-1:0]   b_q;
    logic [AW-1:0]  acc_q;
    logic [W-1:0]   add_q;
    logic [W-1:0]   mul_q;
    logic [CW-1:0]  cnt_q;
    logic [EIW-1:0] ebit_q;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   result_q;
`ifdef MODEXP_RANGE_CHECK_EN
    logic           err_q;
`endif

    logic [AW-1:0]  n_ext;
    logic [AW-1:0]  dbl;
    logic [AW-1:0]  dbl_red;
    logic [AW-1:0]  sum;
    logic [AW-1:0]  acc_d;
    logic [W-1:0]   prod_d;
    logic           last_step;

    // One multiplier step: operands stay below n, so a single conditional subtract
    // after doubling and after adding keeps the accumulator fully reduced.
    always_comb begin
        n_ext     = {2'b00, n_q};
        dbl       = acc_q << 1;
        dbl_red   = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
        sum       = dbl_red + (mul_q[W-1] ? {2'b00, add_q} : {AW{1'b0}});
        acc_d     = (sum >= n_ext) ? (sum - n_ext) : sum;
        prod_d    = acc_d[W-1:0];
        last_step = (cnt_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            r_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            add_q    <= '0;
            mul_q    <= '0;
            cnt_q    <= '0;
            ebit_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef MODEXP_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q  <= base;
                        exp_q   <= exponent;
                        n_q     <= modulus;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    acc_q  <= '0;
                    cnt_q  <= CW'(W - 1);
                    ebit_q <= EIW'(EW - 1);
                    r_q    <= W'(1);
`ifdef MODEXP_RANGE_CHECK_EN
                    if ((n_q < W'(2)) || (base_q >= n_q)) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        // Base is already reduced, so the first square starts at once.
                        err_q   <= 1'b0;
                        b_q     <= base_q;
                        add_q   <= W'(1);
                        mul_q   <= W'(1);
                        state_q <= SQR;
                    end
`else
                    if (n_q < W'(2)) begin
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        // base mod n computed as 1 * base through the same multiplier.
                        add_q   <= W'(1);
                        mul_q   <= base_q;
                        state_q <= RED;
                    end
`endif
                end

                RED: begin
                    acc_q <= acc_d;
                    mul_q <= mul_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_step) begin
                        b_q     <= prod_d;
                        acc_q   <= '0;
                        cnt_q   <= CW'(W - 1);
                        add_q   <= r_q;
                        mul_q   <= r_q;
                        state_q <= SQR;
                    end
                end

                SQR: begin
                    acc_q <= acc_d;
                    mul_q <= mul_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_step) begin
                        r_q   <= prod_d;
                        acc_q <= '0;
                        cnt_q <= CW'(W - 1);
                        if (exp_q[EW-1]) begin
                            add_q   <= b_q;
                            mul_q   <= prod_d;
                            state_q <= MUL;
                        end else if (ebit_q == '0) begin
                            result_q <= prod_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            ebit_q  <= ebit_q - EIW'(1);
                            exp_q   <= exp_q << 1;
                            add_q   <= prod_d;
                            mul_q   <= prod_d;
                            state_q <= SQR;
                        end
                    end
                end

                MUL: begin
                    acc_q <= acc_d;
                    mul_q <= mul_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_step) begin
                        r_q   <= prod_d;
                        acc_q <= '0;
                        cnt_q <= CW'(W - 1);
                        if (ebit_q == '0) begin
                            result_q <= prod_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            ebit_q  <= ebit_q - EIW'(1);
                            exp_q   <= exp_q << 1;
                            add_q   <= prod_d;
                            mul_q   <= prod_d;
                            state_q <= SQR;
                        end
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
`ifdef MODEXP_RANGE_CHECK_EN
    assign err    = err_q;
`endif

endmodule

// File: doc/modexp_engine.md
MODEXP_ENGINE -- requirements
Module: modexp_engine

Interface
REQ-001 SHALL have parameter W, default 16, meaning modulus/base/result width in bits (W >= 2).
REQ-002 SHALL have parameter EW, default 16, meaning exponent width in bits (EW >= 1).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port base  input  W  message/ciphertext operand.
REQ-007 SHALL have port exponent  input  EW  encryption or decryption key.
REQ-008 SHALL have port modulus  input  W  RSA modulus n.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-011 SHALL have port result  output  W  base^exponent mod modulus.
REQ-012 SHALL have port err  output  1  range error flag (present only with MODEXP_RANGE_CHECK_EN).

Function
REQ-013 SHALL implement states IDLE, LOAD, RED, SQR, MUL, DONE.
REQ-014 SHALL, on the edge sampling start=1 in IDLE, latch base, exponent, modulus into internal registers and enter LOAD; inputs are don't-care afterwards.
REQ-015 SHALL ignore start in every state other than IDLE (no queuing, no restart).
REQ-016 SHALL, in LOAD, go directly to DONE with result 0 if latched modulus < 2; otherwise init accumulator R=1 and go to RED.
REQ-017 SHALL, in RED, reduce latched base modulo n over exactly W cycles (MSB-first shift-subtract), then enter SQR for exponent bit EW-1.
REQ-018 SHALL use an interleaved shift-add modular multiplier, one operand bit per cycle, MSB first: acc = 2*acc (-n if >= n), then + a if bit set (-n if >= n); internal acc width W+2; each product takes exactly W cycles.
REQ-019 SHALL, per exponent bit i from EW-1 down to 0: SQR computes R=R*R mod n; if exponent[i]=1 then MUL computes R=R*b mod n; all EW bits processed (no leading-zero skip).
REQ-020 SHALL enter DONE after bit 0 completes, assert done for exactly that one cycle, then return to IDLE.
REQ-021 SHALL hold result stable from DONE until the next LOAD; done low otherwise.
REQ-022 SHALL assert done exactly L rising edges after the edge sampling start, L = 1 + W + W*(EW + popcount(exponent)); L = 1 for modulus < 2.
REQ-023 SHALL produce result 1 for exponent 0 with modulus >= 2.
REQ-024 SHALL accept a new start in the IDLE cycle immediately following DONE.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, busy=0, done=0, result=0, err=0, internal registers 0, asynchronously.
REQ-026 SHALL abandon any operation in progress on rst with no done pulse; first start after rst release is processed normally.

Configuration
REQ-027 SHALL honour macro MODEXP_RANGE_CHECK_EN.
REQ-028 SHALL, with MODEXP_RANGE_CHECK_EN defined: port err exists; LOAD with modulus < 2 or base >= modulus goes to DONE with result 0, err=1, L=1; RED is skipped, so L = 1 + W*(EW + popcount); err cleared at next LOAD.
REQ-029 SHALL, without MODEXP_RANGE_CHECK_EN: no err port, no range check; RED always runs; base >= modulus is reduced, not flagged.

Verification (W=16, EW=16)
REQ-030 SHALL cover encrypt: base=11, exponent=7, modulus=3551 -> result=2834, done at L=321 (305 with macro).
REQ-031 SHALL cover decrypt: base=2834, exponent=1471, modulus=3551 -> result=11, done at L=417 (401 with macro).
REQ-032 SHALL cover edge cases: exponent=0, modulus=3551 -> result=1; modulus=1 -> result=0, L=1.
REQ-033 SHALL cover range: base=3600, exponent=1, modulus=3551 -> result=49 without macro; err=1, result=0, L=1 with macro.
REQ-034 SHALL cover start pulses during busy -> ignored, single done, result unchanged; back-to-back start in IDLE after DONE -> accepted.
REQ-035 SHALL cover rst asserted mid-SQR -> busy=0, result=0 immediately, no done; subsequent 11^7 mod 3551 run -> 2834.
